// File: rtl/pc_fetch_pkg.sv
// Shared fetch-stage constants, branch bus layout and small helpers.
// Imported by the fetch interface, the hold buffer and the fetch top.
package pc_fetch_pkg;

  localparam int STALL_BUS   = 6;
  localparam int BR_WD       = 33;
  localparam int IF_TO_ID_WD = 33;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  // Reset value sits one word below the boot address so the first fetch is 0xBFC0_0000.
  localparam logic [31:0] RESET_VECTOR = 32'hBFBF_FFFC;
  localparam logic [31:0] PC_STEP      = 32'd4;

  typedef enum logic {
    BOOT,
    RUN
  } fetch_state_t;

  typedef struct packed {
    logic        br_e;
    logic [31:0] br_addr;
  } br_bus_t;

  function automatic logic misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/pc_fetch_if.sv
// Bus bundle between the fetch stage, the instruction SRAM and the decode stage.
// The master modport is the fetch side; the slave modport is everything around it.
interface pc_fetch_if
  import pc_fetch_pkg::*;
  ();

  logic [STALL_BUS-1:0]   stall;
  logic [BR_WD-1:0]       br_bus;
  logic [31:0]            inst_sram_rdata;
  logic [IF_TO_ID_WD-1:0] if_to_id_bus;
  logic                   inst_sram_en;
  logic [3:0]             inst_sram_wen;
  logic [31:0]            inst_sram_wdata;
  logic [31:0]            inst_sram_addr;
  logic [31:0]            id_inst;
  logic                   adel;

  modport master (
    input  stall, br_bus, inst_sram_rdata,
    output if_to_id_bus, inst_sram_en, inst_sram_wen, inst_sram_wdata,
           inst_sram_addr, id_inst, adel
  );

  modport slave (
    output stall, br_bus, inst_sram_rdata,
    input  if_to_id_bus, inst_sram_en, inst_sram_wen, inst_sram_wdata,
           inst_sram_addr, id_inst, adel
  );

endinterface

// File: rtl/pc_fetch_inst_hold_buf.sv
// Keeps the instruction word steady for decode while the ID stage is stopped,
// since the synchronous SRAM keeps producing new read data underneath it.
module inst_hold_buf
  import pc_fetch_pkg::*;
  (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_id,
  input  logic [31:0] rdata,
  output logic [31:0] id_inst
);

  logic        hold_valid;
  logic [31:0] hold_inst;

  // Capture only on the first stopped cycle so later SRAM words cannot overwrite it.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_inst  <= '0;
    end else if (stall_id == NO_STOP) begin
      hold_valid <= 1'b0;
    end else if (!hold_valid) begin
      hold_valid <= 1'b1;
      hold_inst  <= rdata;
    end
  end

  assign id_inst = hold_valid ? hold_inst : rdata;

endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch stage: PC register, boot sequencing, stall-tolerant branch
// redirection and the decode-side instruction hold buffer.
module pc_fetch
  import pc_fetch_pkg::*;
  (
  input  logic       clk,
  input  logic       rst,
  pc_fetch_if.master fetch
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic         ce;
  logic         pend_valid;
  logic [31:0]  pend_target;
  logic [31:0]  next_pc;
  logic [31:0]  id_word;
  br_bus_t      br;
  logic         unused_stall;

  assign br           = fetch.br_bus;
  assign unused_stall = ^fetch.stall[STALL_BUS-1:2];

  // A branch that arrived while the PC stage was stopped outranks anything newer.
  always_comb begin
    next_pc = pc + PC_STEP;
    if (pend_valid) begin
      next_pc = pend_target;
    end else if (br.br_e) begin
      next_pc = br.br_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      pc          <= RESET_VECTOR;
      ce          <= 1'b0;
      pend_valid  <= 1'b0;
      pend_target <= '0;
    end else if (fetch.stall[0] == NO_STOP) begin
      pc         <= next_pc;
      ce         <= 1'b1;
      pend_valid <= 1'b0;
      if (state == BOOT) begin
        state <= RUN;
      end
    end else if (br.br_e && !pend_valid) begin
      pend_valid  <= 1'b1;
      pend_target <= br.br_addr;
    end
  end

  inst_hold_buf u_hold (
    .clk      (clk),
    .rst      (rst),
    .stall_id (fetch.stall[1]),
    .rdata    (fetch.inst_sram_rdata),
    .id_inst  (id_word)
  );

  assign fetch.if_to_id_bus    = {ce, pc};
  assign fetch.inst_sram_en    = ce;
  assign fetch.inst_sram_addr  = pc;
  assign fetch.inst_sram_wen   = 4'b0000;
  assign fetch.inst_sram_wdata = 32'h0000_0000;
  assign fetch.id_inst         = id_word;
  assign fetch.adel            = ce & misaligned(pc);

endmodule

// File: tb/tb_pc_fetch.sv
// Directed self-checking bench for the fetch stage: boot, branches, pending
// branches under stall, instruction hold, misaligned fetch and reset mid-flight.
module tb_pc_fetch;
  import pc_fetch_pkg::*;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;

  pc_fetch_if bus ();

  pc_fetch dut (
    .clk   (clk),
    .rst   (rst),
    .fetch (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst                 = 1'b1;
    bus.stall           = '0;
    bus.br_bus          = '0;
    bus.inst_sram_rdata = 32'hDEAD_BEEF;
    tick();
    tick();
    compared++;
    if (bus.inst_sram_en !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_en got=%b want=0", bus.inst_sram_en);
    end
    compared++;
    if (bus.if_to_id_bus !== {1'b0, 32'hBFBF_FFFC}) begin
      mismatched++;
      $display("[TB] FAIL reset_bus got=%h want=%h", bus.if_to_id_bus, {1'b0, 32'hBFBF_FFFC});
    end
    compared++;
    if (bus.adel !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_adel got=%b want=0", bus.adel);
    end
    compared++;
    if (bus.id_inst !== 32'hDEAD_BEEF) begin
      mismatched++;
      $display("[TB] FAIL reset_id_inst got=%h want=deadbeef", bus.id_inst);
    end
    compared++;
    if (bus.inst_sram_wen !== 4'b0000 || bus.inst_sram_wdata !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_write_tie got=%h/%h want=0/0", bus.inst_sram_wen, bus.inst_sram_wdata);
    end
  endtask

  task automatic test_boot();
    logic [31:0] want [3];
    want = '{32'hBFC0_0000, 32'hBFC0_0004, 32'hBFC0_0008};
    rst       = 1'b0;
    bus.stall = 6'b000001;
    tick();
    compared++;
    if (bus.inst_sram_en !== 1'b0 || bus.inst_sram_addr !== 32'hBFBF_FFFC) begin
      mismatched++;
      $display("[TB] FAIL boot_stalled got=%b/%h want=0/bfbffffc", bus.inst_sram_en, bus.inst_sram_addr);
    end
    bus.stall = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      compared++;
      if (bus.inst_sram_addr !== want[i] || bus.inst_sram_en !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL boot_seq%0d got=%b/%h want=1/%h", i, bus.inst_sram_en, bus.inst_sram_addr, want[i]);
      end
    end
  endtask

  task automatic test_branch();
    tick();
    tick();
    compared++;
    if (bus.inst_sram_addr !== 32'hBFC0_0010) begin
      mismatched++;
      $display("[TB] FAIL branch_pre got=%h want=bfc00010", bus.inst_sram_addr);
    end
    bus.br_bus = {1'b1, 32'hBFC0_0100};
    tick();
    bus.br_bus = '0;
    compared++;
    if (bus.inst_sram_addr !== 32'hBFC0_0100) begin
      mismatched++;
      $display("[TB] FAIL branch_taken got=%h want=bfc00100", bus.inst_sram_addr);
    end
  endtask

  task automatic test_pending();
    bus.stall  = 6'b000001;
    bus.br_bus = {1'b1, 32'h8000_0040};
    tick();
    compared++;
    if (bus.inst_sram_addr !== 32'hBFC0_0100) begin
      mismatched++;
      $display("[TB] FAIL pending_hold1 got=%h want=bfc00100", bus.inst_sram_addr);
    end
    bus.br_bus = {1'b1, 32'h8000_0080};
    tick();
    compared++;
    if (bus.inst_sram_addr !== 32'hBFC0_0100) begin
      mismatched++;
      $display("[TB] FAIL pending_hold2 got=%h want=bfc00100", bus.inst_sram_addr);
    end
    bus.stall  = '0;
    bus.br_bus = '0;
    tick();
    compared++;
    if (bus.inst_sram_addr !== 32'h8000_0040) begin
      mismatched++;
      $display("[TB] FAIL pending_first_wins got=%h want=80000040", bus.inst_sram_addr);
    end
    tick();
    compared++;
    if (bus.inst_sram_addr !== 32'h8000_0044) begin
      mismatched++;
      $display("[TB] FAIL pending_cleared got=%h want=80000044", bus.inst_sram_addr);
    end
  endtask

  task automatic test_hold();
    logic [31:0] seq [3];
    seq = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
    bus.stall = 6'b000010;
    for (int i = 0; i < 3; i++) begin
      bus.inst_sram_rdata = seq[i];
      #1;
      compared++;
      if (bus.id_inst !== 32'h1111_1111) begin
        mismatched++;
        $display("[TB] FAIL hold_stalled%0d got=%h want=11111111", i, bus.id_inst);
      end
      tick();
    end
    bus.stall           = '0;
    bus.inst_sram_rdata = 32'h4444_4444;
    #1;
    compared++;
    if (bus.id_inst !== 32'h1111_1111) begin
      mismatched++;
      $display("[TB] FAIL hold_release_cycle got=%h want=11111111", bus.id_inst);
    end
    tick();
    compared++;
    if (bus.id_inst !== 32'h4444_4444) begin
      mismatched++;
      $display("[TB] FAIL hold_follow got=%h want=44444444", bus.id_inst);
    end
    bus.inst_sram_rdata = 32'h5555_5555;
    #1;
    compared++;
    if (bus.id_inst !== 32'h5555_5555) begin
      mismatched++;
      $display("[TB] FAIL hold_follow2 got=%h want=55555555", bus.id_inst);
    end
  endtask

  task automatic test_adel();
    bus.br_bus = {1'b1, 32'hBFC0_0102};
    tick();
    bus.br_bus = '0;
    compared++;
    if (bus.inst_sram_addr !== 32'hBFC0_0102 || bus.adel !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL adel_set got=%h/%b want=bfc00102/1", bus.inst_sram_addr, bus.adel);
    end
    tick();
    compared++;
    if (bus.inst_sram_addr !== 32'hBFC0_0106) begin
      mismatched++;
      $display("[TB] FAIL adel_advance got=%h want=bfc00106", bus.inst_sram_addr);
    end
    bus.br_bus = {1'b1, 32'hBFC0_0200};
    tick();
    bus.br_bus = '0;
    compared++;
    if (bus.adel !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL adel_clear got=%b want=0", bus.adel);
    end
  endtask

  task automatic test_reset_pending();
    bus.stall           = 6'b000011;
    bus.br_bus          = {1'b1, 32'h8000_0100};
    bus.inst_sram_rdata = 32'hAAAA_AAAA;
    tick();
    rst                 = 1'b1;
    bus.br_bus          = '0;
    tick();
    bus.inst_sram_rdata = 32'hBBBB_BBBB;
    #1;
    compared++;
    if (bus.inst_sram_en !== 1'b0 || bus.inst_sram_addr !== 32'hBFBF_FFFC) begin
      mismatched++;
      $display("[TB] FAIL rstpend_reset got=%b/%h want=0/bfbffffc", bus.inst_sram_en, bus.inst_sram_addr);
    end
    compared++;
    if (bus.id_inst !== 32'hBBBB_BBBB) begin
      mismatched++;
      $display("[TB] FAIL rstpend_id_inst got=%h want=bbbbbbbb", bus.id_inst);
    end
    rst       = 1'b0;
    bus.stall = '0;
    tick();
    compared++;
    if (bus.inst_sram_addr !== 32'hBFC0_0000 || bus.inst_sram_en !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL rstpend_first_fetch got=%b/%h want=1/bfc00000", bus.inst_sram_en, bus.inst_sram_addr);
    end
    tick();
    compared++;
    if (bus.inst_sram_addr !== 32'hBFC0_0004) begin
      mismatched++;
      $display("[TB] FAIL rstpend_second_fetch got=%h want=bfc00004", bus.inst_sram_addr);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    test_reset();
    test_boot();
    test_branch();
    test_pending();
    test_hold();
    test_adel();
    test_reset_pending();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock.
REQ-002 SHALL have port rst, input, 1; reset is synchronous, active-high.
REQ-003 SHALL have port stall, input, `StallBus (6), per-stage stop bits: [0] PC stage, [1] ID stage, [2] EX stage; `Stop=1, `NoStop=0.
REQ-004 SHALL have port br_bus, input, `BR_WD (33), {br_e, br_addr[31:0]} from the decode stage.
REQ-005 SHALL have port inst_sram_rdata, input, 32, synchronous SRAM read data (valid one cycle after request).
REQ-006 SHALL have port if_to_id_bus, output, `IF_TO_ID_WD (33), {ce, pc[31:0]}.
REQ-007 SHALL have port inst_sram_en, output, 1, fetch request.
REQ-008 SHALL have ports inst_sram_wen (4) and inst_sram_wdata (32), outputs, tied to zero.
REQ-009 SHALL have port inst_sram_addr, output, 32, fetch address.
REQ-010 SHALL have port id_inst, output, 32, stable instruction word for the decode stage.
REQ-011 SHALL have port adel, output, 1, fetch address misaligned (pc[1:0]!=0) qualified by ce.

Function
REQ-012 SHALL hold a PC register and a ce register; if_to_id_bus = {ce, pc}; inst_sram_en = ce; inst_sram_addr = pc.
REQ-013 SHALL implement states BOOT (after reset, ce=0) and RUN (ce=1); BOOT->RUN on first cycle with stall[0]=NoStop; no other transitions except reset.
REQ-014 SHALL compute next_pc with priority: pending branch target, else br_e ? br_addr : pc+4 (32-bit wrap, no carry out).
REQ-015 SHALL update pc/ce only when stall[0]=NoStop; otherwise hold both.
REQ-016 SHALL latch br_addr into a pending-branch register when br_e=1 and stall[0]=Stop; pending flag is set and cleared on the first NoStop cycle, when pc loads the latched target.
REQ-017 When br_e=1 arrives while a branch is already pending, SHALL keep the earlier target (first branch wins).
REQ-018 When br_e=1 and stall[0]=NoStop in the same cycle with nothing pending, SHALL load br_addr directly; no extra bubble.
REQ-019 SHALL capture inst_sram_rdata into a hold register on the first cycle stall[1]=Stop while hold_valid=0, setting hold_valid.
REQ-020 SHALL drive id_inst = hold_valid ? hold_inst : inst_sram_rdata; clear hold_valid on the first cycle stall[1]=NoStop.
REQ-021 SHALL drive adel combinationally = ce & (pc[1:0]!=2'b00); pc still advances.
REQ-022 Latency: one cycle from stall[0] release to new pc on inst_sram_addr; one further cycle to matching id_inst.

Reset
REQ-023 On rst=1 SHALL set pc=32'hBFBF_FFFC, ce=0, state=BOOT, pending flag=0, pending target=0, hold_valid=0, hold_inst=0.
REQ-024 Reset mid-stall or mid-pending-branch SHALL discard all pending state; first fetch after reset is 32'hBFC0_0000.
REQ-025 Outputs during reset: inst_sram_en=0, if_to_id_bus={1'b0, 32'hBFBF_FFFC}, adel=0, id_inst=inst_sram_rdata.

Structure
REQ-026 `StallBus, `IF_TO_ID_WD, `BR_WD, `Stop/`NoStop and reset vector constant SHALL live in the shared defines header.
REQ-027 SHALL be a single module; the instruction hold buffer MAY be a sub-module named inst_hold_buf.

Verification
REQ-028 Reset release, stall=0 for 3 cycles -> inst_sram_addr 0xBFC00000, 0xBFC00004, 0xBFC00008; ce=1 from cycle 1.
REQ-029 pc=0xBFC00010, br_bus={1,0xBFC00100}, stall=0 -> next inst_sram_addr=0xBFC00100.
REQ-030 stall[0]=1 for 2 cycles with br_e=1 target 0x80000040 in first stalled cycle, then br_e=1 target 0x80000080 -> pc held; after release pc=0x80000040.
REQ-031 stall[1]=1 for 3 cycles with rdata changing 0x11111111->0x22222222->0x33333333 -> id_inst stays 0x11111111; after release follows rdata.
REQ-032 br_bus={1,0xBFC00102} -> adel=1 next cycle with pc=0xBFC00102; next pc 0xBFC00106.
REQ-033 rst asserted while pending branch set -> pending discarded; first fetch after reset 0xBFC00000.
